// File: rtl/write_back_pipe.sv
// Write-back stage: formats ALU/memory results and queues them in front of the register-file port.
// Define WB_FORWARD_EN to build the forwarding lookup over buffered entries.
module write_back_pipe #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_rd,
  input  logic                     in_we,
  input  logic                     in_sel,
  input  logic [1:0]               in_mode,
  input  logic [DATA_W-1:0]        in_alu,
  input  logic [DATA_W-1:0]        in_mem,
  input  logic                     flush,
  input  logic                     rf_ready,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_addr,
  output logic [DATA_W-1:0]        rf_data,
  output logic [DATA_W-1:0]        ans_wb,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              retired,
  input  logic [ADDR_W-1:0]        fwd_rd,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DEPTH-1:0]  we_q, we_d;
  logic [ADDR_W-1:0] rd_q   [DEPTH];
  logic [ADDR_W-1:0] rd_d   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [DATA_W-1:0] ans_q, ans_d;
  logic [15:0]       retired_q, retired_d;

  logic [DATA_W-1:0] raw, fmt;
  logic              empty, head_we, push, pop, commit;

  // Result selection and low-byte extension happen before enqueue.
  always_comb begin
    raw = in_sel ? in_mem : in_alu;
    fmt = raw;
    case (in_mode)
      2'b01: begin
        fmt      = {DATA_W{raw[7]}};
        fmt[7:0] = raw[7:0];
      end
      2'b10: begin
        fmt      = '0;
        fmt[7:0] = raw[7:0];
      end
      default: fmt = raw;
    endcase
  end

  always_comb begin
    empty    = (count_q == '0);
    head_we  = empty ? 1'b0 : we_q[rd_ptr_q];
    in_ready = (count_q < CntW'(DEPTH));
    push     = in_valid & in_ready & ~flush;
    // Non-writing entries drain without waiting for the register file.
    pop      = ~empty & (rf_ready | ~head_we);
    commit   = pop & head_we;
  end

  always_comb begin
    we_d      = we_q;
    rd_d      = rd_q;
    data_d    = data_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ans_d     = ans_q;
    retired_d = retired_q;

    if (push) begin
      we_d[wr_ptr_q]   = in_we & (in_rd != '0);
      rd_d[wr_ptr_q]   = in_rd;
      data_d[wr_ptr_q] = fmt;
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PtrW'(push);
      rd_ptr_d = rd_ptr_q + PtrW'(pop);
      count_d  = count_q + CntW'(push) - CntW'(pop);
    end

    // A head write presented during flush still commits.
    if (commit) begin
      ans_d     = data_q[rd_ptr_q];
      retired_d = retired_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ans_q     <= '0;
      retired_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      we_q      <= we_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ans_q     <= ans_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    rf_we   = head_we;
    rf_addr = empty ? '0 : rd_q[rd_ptr_q];
    rf_data = empty ? '0 : data_q[rd_ptr_q];
    ans_wb  = ans_q;
    count   = count_q;
    retired = retired_q;
  end

`ifdef WB_FORWARD_EN
  logic [PtrW-1:0] fwd_idx;

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = rd_ptr_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PtrW'(i);
      if ((CntW'(i) < count_q) && we_q[fwd_idx] && (rd_q[fwd_idx] == fwd_rd)
          && (fwd_rd != '0)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end
`else
  logic unused_fwd_rd;
  assign unused_fwd_rd = ^fwd_rd;
  assign fwd_hit       = 1'b0;
  assign fwd_data      = '0;
`endif

endmodule
